operand_matcher_stream: RTL

Parametrised, sequential successor to the 8-bit operand matcher. Takes one activation/weight bitmask pair per transaction and computes the mutual (AND) bitmask. For every matched position it emits the dense index into the compressed activation stream and into the compressed weight stream. Results go out as beats of up to LANES index pairs under a valid/ready handshake, so the PE datapath can consume any match count at a fixed lane width.

---
 rtl/operand_matcher_stream.sv | 122 ++++++++++++
 1 files changed

// File: rtl/operand_matcher_stream.sv
// Streaming operand matcher: ANDs an activation/weight bitmask pair and emits
// dense (activation, weight) index pairs for each matched position, up to LANES
// pairs per beat, under a valid/ready handshake.
module operand_matcher_stream #(
  parameter int unsigned BITMASK_LENGTH = 16,
  parameter int unsigned INDEX_BITWIDTH = 4,
  parameter int unsigned LANES          = 4
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                ivalid,
  output logic                                iready,
  input  logic [BITMASK_LENGTH-1:0]           bitmaskA,
  input  logic [BITMASK_LENGTH-1:0]           bitmaskW,
  output logic                                ovalid,
  input  logic                                oready,
  output logic [LANES*INDEX_BITWIDTH-1:0]     oIndexA,
  output logic [LANES*INDEX_BITWIDTH-1:0]     oIndexW,
  output logic [LANES-1:0]                    oLaneMask,
  output logic                                oLast
);

  localparam int unsigned IW   = INDEX_BITWIDTH;
  localparam int unsigned CW   = $clog2(LANES + 1);
  localparam int unsigned PFXW = BITMASK_LENGTH * IW;
  localparam int unsigned OUTW = LANES * IW;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                    state_q;
  logic [BITMASK_LENGTH-1:0] r_q;
  logic [PFXW-1:0]           pa_q;
  logic [PFXW-1:0]           pw_q;

  logic [PFXW-1:0]           pa_d;
  logic [PFXW-1:0]           pw_d;
  logic [IW-1:0]             acc_a;
  logic [IW-1:0]             acc_w;

  logic [BITMASK_LENGTH-1:0] sel;
  logic [CW-1:0]             cnt;
  logic [OUTW-1:0]           idx_a;
  logic [OUTW-1:0]           idx_w;
  logic [LANES-1:0]          lane_mask;
  logic                      last_c;
  logic                      emit_c;
  logic                      accept_c;

  // Exclusive prefix popcounts of the incoming masks (dense stream indices).
  always_comb begin
    acc_a = '0;
    acc_w = '0;
    pa_d  = '0;
    pw_d  = '0;
    for (int i = 0; i < int'(BITMASK_LENGTH); i++) begin
      pa_d[i*IW +: IW] = acc_a;
      pw_d[i*IW +: IW] = acc_w;
      acc_a = acc_a + IW'(bitmaskA[i]);
      acc_w = acc_w + IW'(bitmaskW[i]);
    end
  end

  // Pick the lowest LANES set positions of the remaining mask, packed from lane 0.
  always_comb begin
    cnt       = '0;
    sel       = '0;
    idx_a     = '0;
    idx_w     = '0;
    lane_mask = '0;
    for (int i = 0; i < int'(BITMASK_LENGTH); i++) begin
      if (r_q[i] && (cnt < CW'(LANES))) begin
        for (int k = 0; k < int'(LANES); k++) begin
          if (cnt == CW'(k)) begin
            idx_a[k*IW +: IW] = pa_q[i*IW +: IW];
            idx_w[k*IW +: IW] = pw_q[i*IW +: IW];
          end
        end
        sel[i] = 1'b1;
        cnt    = cnt + CW'(1);
      end
    end
    for (int k = 0; k < int'(LANES); k++) begin
      lane_mask[k] = (CW'(k) < cnt);
    end
  end

  // Handshake and beat outputs; all fields forced to zero outside EMIT.
  assign emit_c    = (state_q == EMIT);
  assign last_c    = ((r_q & ~sel) == '0);
  assign iready    = (state_q == IDLE) || (emit_c && last_c && oready);
  assign accept_c  = ivalid && iready;
  assign ovalid    = emit_c;
  assign oLast     = emit_c && last_c;
  assign oIndexA   = emit_c ? idx_a : '0;
  assign oIndexW   = emit_c ? idx_w : '0;
  assign oLaneMask = emit_c ? lane_mask : '0;

  // State, remaining mask and latched prefix counts.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      r_q     <= '0;
      pa_q    <= '0;
      pw_q    <= '0;
    end else if (accept_c) begin
      // A new transaction may land on the final beat's handshake edge.
      state_q <= EMIT;
      r_q     <= bitmaskA & bitmaskW;
      pa_q    <= pa_d;
      pw_q    <= pw_d;
    end else if (emit_c && oready) begin
      r_q <= r_q & ~sel;
      if (last_c) begin
        state_q <= IDLE;
      end
    end
  end

endmodule
